// File: rtl/analise_ctrl_pkg.sv
// Shared definitions for the analyser sequencer.
// Contents:
//   state_t        - 3-bit controller state encoding
//                    (IDLE=0, CLEAR=1, RUN=2, DRAIN=3, DONE=4)
//   N_DEF, LW_DEF, HW_DEF
//                  - default pattern width, length-input width and hit-counter width
//   sat_inc        - saturating increment helper for the hit counter
package analise_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int N_DEF  = 16;
  localparam int LW_DEF = 5;
  localparam int HW_DEF = 4;

  // Adds one unless the value is already all ones. The caller passes the
  // all-ones value for its own counter width, so this works for any HW up to 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    sat_inc = (value == max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/analise_core.sv
// Analyser under control: a 2-bit counter that advances when ent is high.
// y is high while the counter sits at 3.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset (counter -> 0)
//   clr - synchronous clear (counter -> 0); takes priority over ent
//   ent - count enable
//   y   - high when counter == 3
// y is decoded from the counter flops only, so it has no combinational path
// from ent or clr.
module analise_core (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ent,
  output logic y
);

  logic [1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
    end else if (clr) begin
      cnt <= 2'd0;
    end else if (ent) begin
      cnt <= cnt + 2'd1;
    end
  end

  assign y = (cnt == 2'd3);

endmodule

// File: rtl/analise_ctrl.sv
// Sequencer for one analise_core instance.
// A run latches a bit pattern and a length, clears the analyser, streams the
// pattern LSB first into the analyser's ent input, and counts 0->1 transitions
// of the analyser's y output.
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   start   - run request, sampled only in IDLE
//   pattern - N bits to stream, LSB first; latched when start is accepted
//   len     - number of bits to stream; values above N are clamped to N
//   busy    - high in CLEAR, RUN, DRAIN and DONE
//   done    - one-cycle pulse in DONE
//   hits    - saturating count of y rising edges from the last run
//   ent_o   - analyser count enable
//   clr_o   - analyser synchronous clear
//   y_i     - analyser y output
// Handshake: start is accepted on a rising edge only while busy is low.
// busy rises on the cycle after acceptance and stays high until the DONE
// cycle ends. done pulses for exactly one cycle, len+2 edges after the
// accepting edge. hits is valid from done until the next accepted start.
// A start seen while busy is dropped, not queued.
// All outputs come from flops (state, shift register, hit counter), so there
// is no combinational path from start or y_i to any output.
module analise_ctrl
  import analise_ctrl_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int LW = LW_DEF,
  parameter int HW = HW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  pattern,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [HW-1:0] hits,
  output logic          ent_o,
  output logic          clr_o,
  input  logic          y_i
);

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  shift_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] bit_cnt;
  logic [LW-1:0] bit_cnt_inc;
  logic [LW-1:0] len_clamped;
  logic [HW-1:0] hits_q;
  logic          y_prev;
  logic          last_bit;
  logic          count_en;
  logic          y_rise;

  assign len_clamped = (len > LW'(N)) ? LW'(N) : len;
  assign bit_cnt_inc = bit_cnt + LW'(1);
  // The bit being streamed this cycle is the last one.
  assign last_bit    = (bit_cnt_inc == len_q);
  // Hit sampling covers RUN and DRAIN. DRAIN gives the analyser's response
  // to the final streamed bit one cycle to appear on y_i.
  assign count_en    = (state == S_RUN) || (state == S_DRAIN);
  assign y_rise      = y_i && !y_prev;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    clr_o     = 1'b0;
    ent_o     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy  = 1'b1;
        clr_o = 1'b1;
        state_nxt = (len_q == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        ent_o = shift_q[0];
        if (last_bit) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: pattern shifter, bit counter, hit counter, y history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      len_q   <= '0;
      bit_cnt <= '0;
      hits_q  <= '0;
      y_prev  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shift_q <= pattern;
            len_q   <= len_clamped;
            hits_q  <= '0;
          end
        end
        S_CLEAR: begin
          // The analyser is at 0 after this edge, so y history starts at 0.
          bit_cnt <= '0;
          y_prev  <= 1'b0;
        end
        S_RUN: begin
          shift_q <= shift_q >> 1;
          bit_cnt <= bit_cnt_inc;
        end
        default: begin
        end
      endcase

      if (count_en) begin
        if (y_rise) begin
          hits_q <= HW'(sat_inc(32'(hits_q), 32'({HW{1'b1}})));
        end
        y_prev <= y_i;
      end
    end
  end

  assign hits = hits_q;

endmodule

// File: tb/tb_analise_ctrl.sv
// Bench for analise_ctrl driving analise_core.
// Two controller/analyser pairs run in lockstep on the same start/pattern/len:
// the main pair uses HW=4 and the second pair uses HW=2, which exercises hit
// saturation. Expected hits come from a reference that counts the ones in
// the streamed prefix modulo 4 and counts entries into the value 3. The
// expected ent/clr/busy/done stream comes directly from the run timeline:
// one CLEAR cycle, the streamed bits, one DRAIN cycle, then DONE.
module tb_analise_ctrl;
  import analise_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  len = '0;

  logic       busy_a, done_a, ent_a, clr_a, y_a;
  logic [3:0] hits_a;
  logic       busy_b, done_b, ent_b, clr_b, y_b;
  logic [1:0] hits_b;

  int compared = 0;
  int mismatched = 0;

  // Clock generation.
  always #5 clk = ~clk;

  analise_ctrl #(.N(16), .LW(5), .HW(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .busy(busy_a), .done(done_a), .hits(hits_a),
    .ent_o(ent_a), .clr_o(clr_a), .y_i(y_a)
  );
  analise_core core_a (.clk(clk), .rst(rst), .clr(clr_a), .ent(ent_a), .y(y_a));

  analise_ctrl #(.N(16), .LW(5), .HW(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .busy(busy_b), .done(done_b), .hits(hits_b),
    .ent_o(ent_b), .clr_o(clr_b), .y_i(y_b)
  );
  analise_core core_b (.clk(clk), .rst(rst), .clr(clr_b), .ent(ent_b), .y(y_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the analyser value is the number of ones streamed so far,
  // modulo 4. A hit is each entry into value 3, capped at max_v.
  function automatic int model_hits(input logic [15:0] pat, input int nbits, input int max_v);
    int  ones = 0;
    int  rises = 0;
    bit  prev = 1'b0;
    bit  y;
    for (int k = 0; k < nbits; k++) begin
      ones += int'(pat[k]);
      y = ((ones % 4) == 3);
      if (y && !prev) rises++;
      prev = y;
    end
    return (rises > max_v) ? max_v : rises;
  endfunction

  // Runs one transaction and checks every cycle from acceptance to IDLE.
  // With poke set, start is raised mid-run with a different pattern/len,
  // and the run must not be affected.
  task automatic do_run(input logic [15:0] pat, input int ln, input bit poke);
    int         nb;
    int         exp_ha;
    int         exp_hb;
    logic [3:0] ev;
    nb     = (ln > 16) ? 16 : ln;
    exp_ha = model_hits(pat, nb, 15);
    exp_hb = model_hits(pat, nb, 3);
    @(negedge clk);
    start   = 1'b1;
    pattern = pat;
    len     = ln[4:0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc <= nb + 2; cyc++) begin
      ev = {1'b1, (cyc == nb + 2), (cyc == 0),
            ((cyc >= 1) && (cyc <= nb)) ? pat[(cyc >= 1) ? cyc - 1 : 0] : 1'b0};
      check("ctl_a", 32'({busy_a, done_a, clr_a, ent_a}), 32'(ev));
      check("ctl_b", 32'({busy_b, done_b, clr_b, ent_b}), 32'(ev));
      if (cyc == nb + 2) begin
        check("hits_a", 32'(hits_a), 32'(exp_ha));
        check("hits_b", 32'(hits_b), 32'(exp_hb));
      end
      if (poke && cyc == 1) begin
        start   = 1'b1;
        pattern = ~pat;
        len     = 5'd2;
      end
      if (poke && cyc == 2) start = 1'b0;
      @(posedge clk); #1;
    end
    check("idle_a", 32'({busy_a, done_a, clr_a, ent_a}), 32'd0);
    check("hold_a", 32'(hits_a), 32'(exp_ha));
    check("hold_b", 32'(hits_b), 32'(exp_hb));
  endtask

  // Global bound on the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset block.
    #12;
    check("rst_ctl_a", 32'({busy_a, done_a, clr_a, ent_a}), 32'd0);
    check("rst_ctl_b", 32'({busy_b, done_b, clr_b, ent_b}), 32'd0);
    check("rst_hits_a", 32'(hits_a), 32'd0);
    check("rst_hits_b", 32'(hits_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed runs.
    do_run(16'hFFFF, 16, 1'b0);   // 4 hits, second pair saturates at 3
    do_run(16'h0007, 3, 1'b0);    // hit seen only in DRAIN
    do_run(16'h0000, 8, 1'b0);    // no activity on ent
    do_run(16'hA5A5, 0, 1'b0);    // empty run, done after 2 edges
    do_run(16'hFFFF, 20, 1'b0);   // clamped to 16 bits
    do_run(16'h00FF, 9, 1'b1);    // start pulses while busy are ignored
    do_run(16'h0003, 2, 1'b1);

    // Randomized runs.
    for (int r = 0; r < 24; r++) begin
      do_run(16'($urandom), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
    end

    // Abort with reset while bit 5 is streaming.
    @(negedge clk);
    start   = 1'b1;
    pattern = 16'hFFFF;
    len     = 5'd16;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    start = 1'b1;
    rst   = 1'b1;
    #1;
    check("abort_ctl_a", 32'({busy_a, done_a, clr_a, ent_a}), 32'd0);
    check("abort_ctl_b", 32'({busy_b, done_b, clr_b, ent_b}), 32'd0);
    check("abort_hits_a", 32'(hits_a), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;
    check("post_abort_idle", 32'({busy_a, done_a, clr_a, ent_a}), 32'd0);
    do_run(16'h000F, 4, 1'b0);    // one hit, unaffected by the aborted run

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
